exec_time_monitor: RTL

Synthesizable multi-channel kernel execution-time monitor for heepatia accelerators such as NM-Carus and NM-Caesar. It generalises the single start/done timing measurement to NumCh independent channels. Each channel is gated by a level trigger and accumulates last/total/max duration, execution count and a timeout flag. Statistics are read back through a registered select port by a bus adapter or the testbench.

---
 rtl/exec_time_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/exec_time_monitor.sv
// exec_time_monitor: NumCh-channel kernel execution-time monitor (last/total/count/max, timeout).
// Define EXEC_MON_MIN_EN to add a per-channel min register readable with rd_sel_i=4.
module exec_time_monitor #(
    parameter int unsigned NumCh      = 4,
    parameter int unsigned CntWidth   = 32,
    parameter int unsigned EvtWidth   = 16,
    parameter int unsigned TailCycles = 0,
    localparam int unsigned ChW       = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [NumCh-1:0]    trig_i,
    input  logic [CntWidth-1:0] timeout_i,
    output logic [NumCh-1:0]    done_o,
    output logic [NumCh-1:0]    timeout_o,
    output logic [NumCh-1:0]    multi_exec_o,
    input  logic                rd_req_i,
    input  logic [ChW-1:0]      rd_ch_i,
    input  logic [2:0]          rd_sel_i,
    output logic                rd_valid_o,
    output logic [CntWidth-1:0] rd_data_o
);
    typedef enum logic [1:0] {IDLE, RUN, TMO} state_e;

    state_e              state_q [NumCh];
    state_e              state_d [NumCh];
    logic [CntWidth-1:0] run_q   [NumCh];
    logic [CntWidth-1:0] run_d   [NumCh];
    logic [CntWidth-1:0] last_q  [NumCh];
    logic [CntWidth-1:0] last_d  [NumCh];
    logic [CntWidth-1:0] total_q [NumCh];
    logic [CntWidth-1:0] total_d [NumCh];
    logic [CntWidth-1:0] max_q   [NumCh];
    logic [CntWidth-1:0] max_d   [NumCh];
    logic [EvtWidth-1:0] count_q [NumCh];
    logic [EvtWidth-1:0] count_d [NumCh];
    logic [CntWidth:0]   dur_ext [NumCh];
    logic [CntWidth-1:0] dur     [NumCh];
    logic [CntWidth:0]   tot_ext [NumCh];
`ifdef EXEC_MON_MIN_EN
    logic [CntWidth-1:0] min_q   [NumCh];
    logic [CntWidth-1:0] min_d   [NumCh];
`endif
    logic [NumCh-1:0]    trig_q, trig_d;
    logic [NumCh-1:0]    done_q, done_d;
    logic [NumCh-1:0]    tmo_q, tmo_d;
    logic                rd_valid_q, rd_valid_d;
    logic [CntWidth-1:0] rd_data_q, rd_data_d;
    logic [CntWidth-1:0] rd_min;

    always_comb begin
        trig_d     = trig_i;
        done_d     = '0;
        tmo_d      = tmo_q;
        rd_valid_d = rd_req_i;
        rd_data_d  = '0;
        rd_min     = '0;
        for (int i = 0; i < NumCh; i++) begin
            state_d[i] = state_q[i];
            run_d[i]   = run_q[i];
            last_d[i]  = last_q[i];
            total_d[i] = total_q[i];
            max_d[i]   = max_q[i];
            count_d[i] = count_q[i];
`ifdef EXEC_MON_MIN_EN
            min_d[i]   = min_q[i];
`endif
            dur_ext[i] = {1'b0, run_q[i]} + (CntWidth+1)'(TailCycles);
            dur[i]     = dur_ext[i][CntWidth] ? '1 : dur_ext[i][CntWidth-1:0];
            tot_ext[i] = {1'b0, total_q[i]} + {1'b0, dur[i]};
            if (clear_i) begin
                state_d[i] = IDLE;
                run_d[i]   = '0;
                last_d[i]  = '0;
                total_d[i] = '0;
                max_d[i]   = '0;
                count_d[i] = '0;
                tmo_d[i]   = 1'b0;
`ifdef EXEC_MON_MIN_EN
                min_d[i]   = '1;
`endif
            end else begin
                case (state_q[i])
                    IDLE: if (trig_i[i] && !trig_q[i]) begin
                        state_d[i] = RUN;
                        run_d[i]   = CntWidth'(1);
                    end
                    RUN: if (!trig_i[i]) begin
                        state_d[i] = IDLE;
                        done_d[i]  = 1'b1;
                        last_d[i]  = dur[i];
                        total_d[i] = tot_ext[i][CntWidth] ? '1 : tot_ext[i][CntWidth-1:0];
                        count_d[i] = (count_q[i] == '1) ? count_q[i] : count_q[i] + EvtWidth'(1);
                        max_d[i]   = (dur[i] > max_q[i]) ? dur[i] : max_q[i];
`ifdef EXEC_MON_MIN_EN
                        min_d[i]   = (dur[i] < min_q[i]) ? dur[i] : min_q[i];
`endif
                    end else if (timeout_i != '0 && run_q[i] == timeout_i) begin
                        state_d[i] = TMO;
                        tmo_d[i]   = 1'b1;
                    end else begin
                        run_d[i] = (run_q[i] == '1) ? run_q[i] : run_q[i] + CntWidth'(1);
                    end
                    TMO: if (!trig_i[i]) state_d[i] = IDLE;
                    default: state_d[i] = IDLE;
                endcase
            end
        end
        // Readout samples pre-update state, so a same-cycle stop is not visible yet.
        if (rd_req_i && 32'(rd_ch_i) < NumCh) begin
`ifdef EXEC_MON_MIN_EN
            rd_min = (count_q[rd_ch_i] == '0) ? '0 : min_q[rd_ch_i];
`endif
            rd_data_d = (rd_sel_i == 3'd0) ? last_q[rd_ch_i] :
                        (rd_sel_i == 3'd1) ? total_q[rd_ch_i] :
                        (rd_sel_i == 3'd2) ? CntWidth'(count_q[rd_ch_i]) :
                        (rd_sel_i == 3'd3) ? max_q[rd_ch_i] :
                        (rd_sel_i == 3'd4) ? rd_min : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCh; i++) begin
                state_q[i] <= IDLE;
                run_q[i]   <= '0;
                last_q[i]  <= '0;
                total_q[i] <= '0;
                max_q[i]   <= '0;
                count_q[i] <= '0;
`ifdef EXEC_MON_MIN_EN
                min_q[i]   <= '1;
`endif
            end
            trig_q     <= '0;
            done_q     <= '0;
            tmo_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                state_q[i] <= state_d[i];
                run_q[i]   <= run_d[i];
                last_q[i]  <= last_d[i];
                total_q[i] <= total_d[i];
                max_q[i]   <= max_d[i];
                count_q[i] <= count_d[i];
`ifdef EXEC_MON_MIN_EN
                min_q[i]   <= min_d[i];
`endif
            end
            trig_q     <= trig_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NumCh; i++) multi_exec_o[i] = count_q[i] > EvtWidth'(1);
    end

    assign done_o     = done_q;
    assign timeout_o  = tmo_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
endmodule
